// File: rtl/relu_maxpool_2x2.sv
// ReLU + requantisation followed by a 2x2 stride-2 max-pool over a raster stream.
// A half-width row buffer carries even-row horizontal maxima to the odd row.
module relu_maxpool_2x2 #(
  parameter int IMG_WIDTH = 1920,
  parameter int DATA_W    = 20,
  parameter int SHIFT     = 4,
  parameter int OUT_W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] conv_in,
  input  logic                     conv_valid,
  input  logic [10:0]              x_in,
  input  logic [9:0]               y_in,
  output logic [OUT_W-1:0]         pool_out,
  output logic                     pool_valid,
  output logic [9:0]               x_pool,
  output logic [8:0]               y_pool
);

  localparam int DEPTH = (IMG_WIDTH / 2 > 0) ? IMG_WIDTH / 2 : 1;
  localparam int AW    = ($clog2(DEPTH) > 0) ? $clog2(DEPTH) : 1;
  localparam logic signed [DATA_W-1:0] CEIL = DATA_W'((2 ** OUT_W) - 1);

  logic [OUT_W-1:0] rowbuf [DEPTH];

  logic signed [DATA_W-1:0] shifted;
  logic [OUT_W-1:0]         relu_q;
  logic                     in_range;
  logic                     rd_en;
  logic [AW-1:0]            rd_addr;

  logic                     v1;
  logic [OUT_W-1:0]         r1;
  logic [10:0]              x1;
  logic [9:0]               y1;
  logic [OUT_W-1:0]         rd_data;

  logic [OUT_W-1:0]         hold;
  logic [10:0]              hold_tag;
  logic                     hold_tag_valid;

  logic                     pair_ok;
  logic [OUT_W-1:0]         h_max;
  logic [OUT_W-1:0]         v_max;
  logic                     wr_en;
  logic [AW-1:0]            wr_addr;

  // Shift and clamp at full input width so large accumulators saturate instead of wrapping.
  always_comb begin
    shifted = conv_in >>> SHIFT;
    relu_q  = '0;
    if (conv_in[DATA_W-1])
      relu_q = '0;
    else if (shifted > CEIL)
      relu_q = '1;
    else
      relu_q = shifted[OUT_W-1:0];
  end

  always_comb begin
    in_range = (32'(x_in) < IMG_WIDTH);
    rd_en    = conv_valid && in_range && (32'(x_in >> 1) < DEPTH);
    rd_addr  = AW'(x_in >> 1);
  end

  always_comb begin
    pair_ok = v1 && x1[0] && hold_tag_valid && (hold_tag == 11'(x1 - 11'd1));
    h_max   = (hold > r1) ? hold : r1;
    v_max   = (h_max > rd_data) ? h_max : rd_data;
    wr_en   = !reset && pair_ok && !y1[0];
    wr_addr = AW'(x1 >> 1);
  end

  // Row buffer is deliberately not reset; even rows overwrite entries before odd rows read them.
  always_ff @(posedge clk) begin
    if (wr_en)
      rowbuf[wr_addr] <= h_max;
    if (rd_en)
      rd_data <= rowbuf[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1             <= 1'b0;
      r1             <= '0;
      x1             <= '0;
      y1             <= '0;
      hold           <= '0;
      hold_tag       <= '0;
      hold_tag_valid <= 1'b0;
      pool_out       <= '0;
      pool_valid     <= 1'b0;
      x_pool         <= '0;
      y_pool         <= '0;
    end else begin
      v1         <= conv_valid && in_range;
      r1         <= relu_q;
      x1         <= x_in;
      y1         <= y_in;
      pool_valid <= 1'b0;
      if (v1 && !x1[0]) begin
        hold           <= r1;
        hold_tag       <= x1;
        hold_tag_valid <= 1'b1;
      end else if (pair_ok) begin
        hold_tag_valid <= 1'b0;
        if (y1[0]) begin
          pool_out   <= v_max;
          pool_valid <= 1'b1;
          x_pool     <= x1[10:1];
          y_pool     <= y1[9:1];
        end
      end
    end
  end

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// Scoreboard bench: directed stimulus pushes hand-computed pooled results, monitors pop and compare.
module tb_relu_maxpool_2x2;

  logic               clk;
  logic               reset;
  logic signed [19:0] conv_in;
  logic [10:0]        x_in;
  logic [9:0]         y_in;
  logic               valid4, valid5;
  logic [7:0]         po4, po5;
  logic               pv4, pv5;
  logic [9:0]         xp4, xp5;
  logic [8:0]         yp4, yp5;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int v;
    int x;
    int y;
    int c;
  } exp_t;

  exp_t q4[$];
  exp_t q5[$];
  exp_t e4, e5;

  relu_maxpool_2x2 #(.IMG_WIDTH(4), .DATA_W(20), .SHIFT(4), .OUT_W(8)) dut4 (
    .clk(clk), .reset(reset), .conv_in(conv_in), .conv_valid(valid4),
    .x_in(x_in), .y_in(y_in), .pool_out(po4), .pool_valid(pv4),
    .x_pool(xp4), .y_pool(yp4)
  );

  relu_maxpool_2x2 #(.IMG_WIDTH(5), .DATA_W(20), .SHIFT(4), .OUT_W(8)) dut5 (
    .clk(clk), .reset(reset), .conv_in(conv_in), .conv_valid(valid5),
    .x_in(x_in), .y_in(y_in), .pool_out(po5), .pool_valid(pv5),
    .x_pool(xp5), .y_pool(yp5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pv4 === 1'b1) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL out4_unexpected: got val=%0d x=%0d y=%0d at cyc=%0d, required no strobe",
                 po4, xp4, yp4, cyc);
      end else begin
        e4 = q4.pop_front();
        if (int'(po4) != e4.v || int'(xp4) != e4.x || int'(yp4) != e4.y || cyc != e4.c) begin
          errors++;
          $display("FAIL out4: got val=%0d x=%0d y=%0d cyc=%0d, required val=%0d x=%0d y=%0d cyc=%0d",
                   po4, xp4, yp4, cyc, e4.v, e4.x, e4.y, e4.c);
        end
      end
    end
    if (pv5 === 1'b1) begin
      checks++;
      if (q5.size() == 0) begin
        errors++;
        $display("FAIL out5_unexpected: got val=%0d x=%0d y=%0d at cyc=%0d, required no strobe",
                 po5, xp5, yp5, cyc);
      end else begin
        e5 = q5.pop_front();
        if (int'(po5) != e5.v || int'(xp5) != e5.x || int'(yp5) != e5.y || cyc != e5.c) begin
          errors++;
          $display("FAIL out5: got val=%0d x=%0d y=%0d cyc=%0d, required val=%0d x=%0d y=%0d cyc=%0d",
                   po5, xp5, yp5, cyc, e5.v, e5.x, e5.y, e5.c);
        end
      end
    end
  end

  task automatic send(input bit to5, input int v, input int x, input int y);
    @(negedge clk);
    conv_in = 20'(v);
    x_in    = 11'(x);
    y_in    = 10'(y);
    valid4  = !to5;
    valid5  = to5;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid4 = 1'b0;
      valid5 = 1'b0;
    end
  endtask

  // Called right after the tile-completing send: strobe is seen at the negedge two edges later.
  task automatic exp4(input int v, input int x, input int y);
    q4.push_back('{v, x, y, cyc + 2});
  endtask

  task automatic exp5(input int v, input int x, input int y);
    q5.push_back('{v, x, y, cyc + 2});
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (pv4 !== 1'b0 || po4 !== 8'd0 || xp4 !== 10'd0 || yp4 !== 9'd0 ||
        pv5 !== 1'b0 || po5 !== 8'd0 || xp5 !== 10'd0 || yp5 !== 9'd0) begin
      errors++;
      $display("FAIL %s: got pv4=%0b po4=%0d xp4=%0d yp4=%0d pv5=%0b po5=%0d, required all 0",
               name, pv4, po4, xp4, yp4, pv5, po5);
    end
  endtask

  task automatic frame2(input bit gaps);
    int row0[4];
    int row1[4];
    row0 = '{160, 320, -570, 800};
    row1 = '{480, 16, 5000, 0};
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 4; x++) begin
        send(1'b0, (y == 0) ? row0[x] : row1[x], x, y);
        if (y == 1 && x == 1) exp4(30, 0, 0);
        if (y == 1 && x == 3) exp4(255, 1, 0);
        if (gaps) idle($urandom_range(0, 3));
      end
    end
    idle(1);
  endtask

  initial begin
    int reqv[5];
    int reqe[5];
    reqv = '{-570, 1600, 5000, 4095, 4079};
    reqe = '{0, 100, 255, 255, 254};

    reset = 1'b1; valid4 = 1'b0; valid5 = 1'b0;
    conv_in = '0; x_in = '0; y_in = '0;
    idle(3);
    check_zero("reset_state");
    @(negedge clk);
    reset = 1'b0;

    // Requant: uniform tiles, one tile per row pair so y_pool steps with k.
    for (int k = 0; k < 5; k++) begin
      send(1'b0, reqv[k], 0, 2 * k);
      send(1'b0, reqv[k], 1, 2 * k);
      send(1'b0, reqv[k], 0, 2 * k + 1);
      send(1'b0, reqv[k], 1, 2 * k + 1);
      exp4(reqe[k], 0, k);
      idle(1);
    end
    idle(3);

    frame2(1'b0);
    idle(3);
    frame2(1'b1);
    idle(3);

    // Odd width: x=4 has no partner, x=5 is outside the frame.
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 6; x++) begin
        send(1'b1, 1600, x, y);
        if (y == 1 && x == 1) exp5(100, 0, 0);
        if (y == 1 && x == 3) exp5(100, 1, 0);
      end
    end
    idle(4);

    // Broken pair: row1 x=0 missing, so tile 0 never completes.
    send(1'b0, 1600, 0, 0);
    send(1'b0, 1600, 1, 0);
    send(1'b0, 800, 2, 0);
    send(1'b0, 160, 3, 0);
    send(1'b0, 1600, 1, 1);
    send(1'b0, 480, 2, 1);
    send(1'b0, 16, 3, 1);
    exp4(50, 1, 0);
    idle(4);

    // Reset lands on the edge that would register the (0,0) tile result.
    send(1'b0, 160, 0, 0);
    send(1'b0, 320, 1, 0);
    send(1'b0, 480, 0, 1);
    send(1'b0, 16, 1, 1);
    @(negedge clk);
    valid4 = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_zero("reset_mid_frame");
    idle(1);
    check_zero("reset_mid_frame_after");
    frame2(1'b0);
    idle(4);

    checks++;
    if (q4.size() != 0 || q5.size() != 0) begin
      errors++;
      $display("FAIL drain: got pending q4=%0d q5=%0d, required 0 0", q4.size(), q5.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
